// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - state encoding and baud helper shared by the UART transmit and receive paths
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Clock cycles per bit, rounded to nearest so the baud error stays symmetric.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake between an upstream producer and the UART transmitter
interface uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - per-bit cycle counter with clear/enable and a bit_done pulse
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_done_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done_o = en_i && (cnt_q == LAST);

  // Wrapping on bit_done keeps every bit exactly CLKS_PER_BIT cycles long.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || bit_done_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with valid/ready byte input and registered TX line
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic      CLK50M,
  input  logic      RST_N,
  uart_tx_if.slave  up,
  output logic      TX,
  output logic      busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  logic [1:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_q, tx_d;
  logic       accept;
  logic       bit_done;

  assign up.tx_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign accept      = up.tx_valid && up.tx_ready;
  assign TX          = tx_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i      (CLK50M),
    .rst_ni     (RST_N),
    .clr_i      (accept),
    .en_i       (busy),
    .bit_done_o (bit_done)
  );

  // tx_d always carries the level of the bit that starts at the next edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = up.tx_data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK50M) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      shift_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx at 10 clocks per bit
module tb_uart_tx;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;

  logic CLK50M = 1'b0;
  logic RST_N  = 1'b0;
  logic TX;
  logic busy;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .CLK50M(CLK50M),
    .RST_N (RST_N),
    .up    (bus.slave),
    .TX    (TX),
    .busy  (busy)
  );

  always #5 CLK50M = ~CLK50M;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: frame position counted in cycles since accept; -1 means idle.
  int         m_pos  = -1;
  logic [7:0] m_byte = 8'd0;
  int         m_acc  = 0;

  always @(posedge CLK50M) begin
    if (!RST_N) begin
      m_pos <= -1;
    end else if (m_pos < 0) begin
      if (bus.tx_valid) begin
        m_pos  <= 0;
        m_byte <= bus.tx_data;
        m_acc  <= m_acc + 1;
      end
    end else if (m_pos == FRAME - 1) begin
      m_pos <= -1;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  function automatic logic exp_tx(input int pos, input logic [7:0] b);
    int slot;
    if (pos < 0) return 1'b1;
    slot = pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  always @(negedge CLK50M) begin
    if (chk_en) begin
      check("model_tx",    int'(TX),           int'(exp_tx(m_pos, m_byte)));
      check("model_busy",  int'(busy),         int'(m_pos >= 0));
      check("model_ready", int'(bus.tx_ready), int'(m_pos < 0));
    end
  end

  // TX is registered, so it may only move on a rising clock edge (t = 5 mod 10).
  always @(TX) begin
    if (chk_en) check("tx_edge_align", int'($time % 64'd10), 5);
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    bit         change_data;
    bit         pulse_valid;
  } vec_t;

  vec_t vecs[4];

  task automatic send(input logic [7:0] d);
    int a0;
    @(negedge CLK50M);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    a0 = m_acc;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK50M);
      #1;
      if (m_acc != a0) return;
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic run_frame(input vec_t v);
    send(v.data);
    for (int c = 0; c <= FRAME; c++) begin
      @(negedge CLK50M);
      if (c % CPB == CPB / 2 && c < FRAME)
        check($sformatf("bit%0d_of_%02h", c / CPB, v.data), int'(TX), int'(v.line[c/CPB]));
      if (c == FRAME - 1) check("ready_low_end", int'(bus.tx_ready), 0);
      if (c == FRAME) check("ready_back", int'(bus.tx_ready), 1);
      if (c == 0) begin
        bus.tx_valid = 1'b0;
        if (v.change_data) bus.tx_data = 8'hFF;
      end
      if (v.pulse_valid && (c == 30 || c == 70)) bus.tx_valid = 1'b1;
      if (v.pulse_valid && (c == 31 || c == 71)) bus.tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK50M);
      if (m_pos < 0) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, highs, run, final_run, a0;

    vecs[0] = '{8'h61, 10'b1011000010, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 10'b1101001010, 1'b1, 1'b1};
    vecs[2] = '{8'h3C, 10'b1001111000, 1'b0, 1'b1};
    vecs[3] = '{8'h0F, 10'b1000011110, 1'b0, 1'b0};

    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    RST_N        = 1'b0;
    repeat (2) @(negedge CLK50M);
    chk_en = 1'b1;
    check("rst_tx",    int'(TX),           1);
    check("rst_ready", int'(bus.tx_ready), 1);
    check("rst_busy",  int'(busy),         0);
    RST_N = 1'b1;

    lows = 0;
    repeat (50) begin
      @(negedge CLK50M);
      if (TX !== 1'b1 || busy !== 1'b0 || bus.tx_ready !== 1'b1) lows++;
    end
    check("idle_50", lows, 0);

    for (int i = 0; i < 3; i++) begin
      run_frame(vecs[i]);
      wait_idle();
    end

    // Back-to-back: valid held high across two frames.
    send(8'h00);
    a0 = m_acc;
    run = 0;
    final_run = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK50M);
      if (c == 0) bus.tx_data = 8'hFF;
      if (m_acc != a0) bus.tx_valid = 1'b0;
      if (TX === 1'b1) begin
        run++;
      end else if (run > 0) begin
        final_run = run;
        break;
      end
    end
    check("b2b_gap_high", final_run, CPB + 1);
    check("b2b_second_accept", m_acc - a0, 1);
    wait_idle();

    // Reset in the middle of data bit 3.
    send(8'h55);
    for (int c = 0; c <= 44; c++) begin
      @(negedge CLK50M);
      if (c == 0) bus.tx_valid = 1'b0;
    end
    RST_N = 1'b0;
    @(negedge CLK50M);
    check("midrst_tx",    int'(TX),           1);
    check("midrst_ready", int'(bus.tx_ready), 1);
    check("midrst_busy",  int'(busy),         0);
    RST_N = 1'b1;
    run_frame(vecs[3]);
    wait_idle();

    // Start/stop width using all-ones and all-zeros payloads.
    for (int k = 0; k < 2; k++) begin
      send(k == 0 ? 8'hFF : 8'h00);
      lows = 0;
      highs = 0;
      for (int c = 0; c <= FRAME; c++) begin
        @(negedge CLK50M);
        if (c == 0) bus.tx_valid = 1'b0;
        if (busy === 1'b1) begin
          if (TX === 1'b0) lows++;
          else highs++;
        end
      end
      check($sformatf("low_cycles_%0d", k),  lows,  (k == 0) ? CPB : 9 * CPB);
      check($sformatf("high_cycles_%0d", k), highs, (k == 0) ? 9 * CPB : CPB);
      wait_idle();
    end

    // Random bytes, gaps, data noise and ignored valid pulses; the model checks every cycle.
    repeat (25) begin
      repeat ($urandom_range(0, 15)) begin
        @(negedge CLK50M);
        bus.tx_data = 8'($urandom);
      end
      send(8'($urandom));
      for (int i = 0; i < 300; i++) begin
        @(negedge CLK50M);
        if (m_pos < 0) break;
        bus.tx_data  = 8'($urandom);
        bus.tx_valid = (m_pos < FRAME - CPB) ? 1'($urandom) : 1'b0;
      end
      bus.tx_valid = 1'b0;
    end

    repeat (5) @(negedge CLK50M);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
